exb_lane_alu_pipe: RTL and testbench

Parametrised execute unit for lane 2+ of the JX2 core. It replaces the single-cycle lane-2+ EX1 stage with a depth-configurable in-order pipeline. The pipeline covers immediate loads (LDI/LDISHx), 32-bit and full-width shifts, and MOVT/MOVNT. It also provides predication, branch flush, downstream stall, held-destination reporting for the interlock logic, and a sticky fault hold for unsupported operations.

---
 rtl/exb_lane_alu_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_exb_lane_alu_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exb_lane_alu_pipe.sv
// Lane 2+ execute pipe: LDI/LDISHx, SHAD3 shifts and MOVT/MOVNT; result after PIPE_L cycles, and exStall freezes every stage.
// Rotate forms of SHAD3 are enabled by defining JX2_EXB_SHAD_ROT_EN; without it they raise the sticky fault.
module exb_lane_alu_pipe #(
    parameter int DATA_W = 64,
    parameter int ID_W   = 6,
    parameter int PIPE_L = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        opUCmd,
    input  logic [7:0]        opUIxt,
    input  logic              opBraFlush,
    input  logic              exStall,
    input  logic [ID_W-1:0]   regIdRm,
    input  logic [DATA_W-1:0] regValRs,
    input  logic [7:0]        regValRt,
    input  logic [32:0]       regValImm,
    input  logic              regInSrT,
    output logic [ID_W-1:0]   regIdRn,
    output logic [DATA_W-1:0] regValRn,
    output logic [ID_W-1:0]   heldIdRn,
    output logic [1:0]        exHold,
    output logic [7:0]        opUCmdOut
);

    localparam logic [5:0]      UCMD_NOP    = 6'h00;
    localparam logic [5:0]      UCMD_OP_IXS = 6'h01;
    localparam logic [5:0]      UCMD_MOV_IR = 6'h06;
    localparam logic [5:0]      UCMD_SHAD3  = 6'h0F;
    localparam logic [7:0]      IXS_NOP     = 8'h00;
    localparam logic [7:0]      IXS_MOVT    = 8'h04;
    localparam logic [7:0]      IXS_MOVNT   = 8'h05;
    localparam logic [1:0]      IXC_AL      = 2'b00;
    localparam logic [ID_W-1:0] GR_ZZR      = '1;

    typedef enum logic [2:0] {SK_PASS, SK_SHL, SK_SHR, SK_SAR, SK_ROL32, SK_ROLW} shKind_t;
    typedef enum logic [1:0] {EX_NONE, EX_Z32, EX_S32} extMode_t;

    typedef struct packed {
        logic              vld;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] val;
        shKind_t           kind;
        logic [2:0]        fine;
        extMode_t          ext;
    } stage_t;

    stage_t stg [PIPE_L];
    stage_t iss, issOut, fin0;
    logic   faultQ;
    logic   condOk, en, handled, neg, unhandled;
    logic [5:0]        effOp;
    logic [7:0]        mag, shAmt;
    logic [DATA_W-1:0] src, zxRs;
    logic [95:0]       sxImm, sxRs;
    logic [DATA_W+7:0]  movB;
    logic [DATA_W+15:0] movH;
    logic [DATA_W+31:0] movW;

    assign sxImm = {{63{regValImm[32]}}, regValImm};
    assign sxRs  = {{64{regValRs[31]}}, regValRs[31:0]};
    assign zxRs  = DATA_W'(regValRs[31:0]);
    assign movB  = {regValRs, regValImm[7:0]};
    assign movH  = {regValRs, regValImm[15:0]};
    assign movW  = {regValRs, regValImm[31:0]};

    // Rotates work on a 32-bit ring or the full word; other kinds are plain shifts.
    function automatic logic [DATA_W-1:0] shiftBy(input logic [DATA_W-1:0] x, input shKind_t k,
                                                  input logic [7:0] n);
        logic [31:0]       lo;
        logic [DATA_W-1:0] r;
        r = x;
        case (k)
            SK_SHL:   r = x << n;
            SK_SHR:   r = x >> n;
            SK_SAR:   r = $unsigned($signed(x) >>> n);
            SK_ROL32: begin
                lo = (x[31:0] << n[4:0]) | (x[31:0] >> (6'd32 - {1'b0, n[4:0]}));
                r  = DATA_W'(lo);
            end
            SK_ROLW:  r = (x << n) | (x >> (DATA_W - int'(n)));
            default:  r = x;
        endcase
        return r;
    endfunction

    function automatic stage_t finishStage(input stage_t s);
        stage_t      r;
        logic [95:0] sx;
        r     = s;
        r.val = shiftBy(s.val, s.kind, {5'd0, s.fine});
        sx    = {{64{r.val[31]}}, r.val[31:0]};
        case (s.ext)
            EX_Z32:  r.val = DATA_W'(r.val[31:0]);
            EX_S32:  r.val = sx[DATA_W-1:0];
            default: ;
        endcase
        r.kind = SK_PASS;
        r.fine = '0;
        r.ext  = EX_NONE;
        return r;
    endfunction

    always_comb begin
        case (opUCmd[7:6])
            2'b00:   condOk = 1'b1;
            2'b01:   condOk = 1'b0;
            2'b10:   condOk = regInSrT;
            default: condOk = !regInSrT;
        endcase
        en      = condOk && !opBraFlush;
        effOp   = en ? opUCmd[5:0] : UCMD_NOP;
        neg     = regValRt[7];
        mag     = neg ? (8'd0 - regValRt) : regValRt;
        handled = 1'b0;
        iss     = '0;
        src     = '0;
        shAmt   = '0;
        case (effOp)
            UCMD_NOP: handled = 1'b1;
            UCMD_MOV_IR: begin
                handled = 1'b1;
                iss.vld = 1'b1;
                case (opUIxt[3:0])
                    4'd0: src = sxImm[DATA_W-1:0];
                    4'd1: src = movB[DATA_W-1:0];
                    4'd2: src = movH[DATA_W-1:0];
                    4'd3: begin
                        if (DATA_W == 64) src = movW[DATA_W-1:0];
                        else begin
                            handled = 1'b0;
                            iss.vld = 1'b0;
                        end
                    end
                    default: begin
                        handled = 1'b0;
                        iss.vld = 1'b0;
                    end
                endcase
            end
            UCMD_SHAD3: begin
                if (!opUIxt[2]) begin
                    handled  = 1'b1;
                    iss.vld  = 1'b1;
                    shAmt    = mag;
                    iss.kind = neg ? (opUIxt[0] ? SK_SAR : SK_SHR) : SK_SHL;
                    // 32-bit forms shift a pre-extended word and re-extend bit 31 at the end.
                    case (opUIxt[1:0])
                        2'b00: begin src = zxRs;              iss.ext = EX_Z32; end
                        2'b01: begin src = sxRs[DATA_W-1:0];  iss.ext = EX_S32; end
                        default: src = regValRs;
                    endcase
                end
`ifdef JX2_EXB_SHAD_ROT_EN
                else begin
                    handled = 1'b1;
                    iss.vld = 1'b1;
                    src     = regValRs;
                    if (opUIxt[1]) begin
                        iss.kind = SK_ROLW;
                        shAmt    = regValRt & 8'(DATA_W - 1);
                    end else begin
                        iss.kind = SK_ROL32;
                        shAmt    = regValRt & 8'd31;
                        iss.ext  = opUIxt[0] ? EX_S32 : EX_Z32;
                    end
                end
`endif
            end
            UCMD_OP_IXS: begin
                case (opUIxt)
                    IXS_NOP:   handled = 1'b1;
                    IXS_MOVT:  begin handled = 1'b1; iss.vld = 1'b1; src = DATA_W'(regInSrT);  end
                    IXS_MOVNT: begin handled = 1'b1; iss.vld = 1'b1; src = DATA_W'(!regInSrT); end
                    default:   ;
                endcase
            end
            default: ;
        endcase
        // Coarse part (multiple of 8) now, the remaining 0..7 one stage later.
        iss.id    = regIdRm;
        iss.fine  = shAmt[2:0];
        iss.val   = shiftBy(src, iss.kind, shAmt & 8'hF8);
        unhandled = en && !handled;
        issOut    = (PIPE_L == 1) ? finishStage(iss) : iss;
        fin0      = finishStage(stg[0]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_L; i++) stg[i] <= '0;
            faultQ <= 1'b0;
        end else if (!exStall) begin
            faultQ <= faultQ | unhandled;
            stg[0] <= issOut;
            for (int i = 1; i < PIPE_L; i++) stg[i] <= (i == 1) ? fin0 : stg[i-1];
        end
    end

    always_comb begin
        heldIdRn = GR_ZZR;
        for (int i = 0; i < PIPE_L - 1; i++) begin
            if (stg[i].vld) heldIdRn = stg[i].id;
        end
    end

    assign regIdRn   = stg[PIPE_L-1].vld ? stg[PIPE_L-1].id : GR_ZZR;
    assign regValRn  = stg[PIPE_L-1].val;
    assign exHold    = {heldIdRn != GR_ZZR, faultQ};
    assign opUCmdOut = {IXC_AL, effOp};

endmodule

// File: tb/tb_exb_lane_alu_pipe.sv
// Directed bench for exb_lane_alu_pipe at DATA_W=64, PIPE_L=2.
module tb_exb_lane_alu_pipe;

    localparam logic [5:0] ZZR         = 6'h3F;
    localparam logic [5:0] UCMD_NOP    = 6'h00;
    localparam logic [5:0] UCMD_OP_IXS = 6'h01;
    localparam logic [5:0] UCMD_MOV_IR = 6'h06;
    localparam logic [5:0] UCMD_SHAD3  = 6'h0F;
    localparam logic [5:0] UCMD_INVOP  = 6'h3F;
    localparam logic [7:0] IXS_MOVT    = 8'h04;
    localparam logic [7:0] IXS_MOVNT   = 8'h05;

    logic        clock, reset;
    logic [7:0]  opUCmd, opUIxt;
    logic        opBraFlush, exStall;
    logic [5:0]  regIdRm;
    logic [63:0] regValRs;
    logic [7:0]  regValRt;
    logic [32:0] regValImm;
    logic        regInSrT;
    logic [5:0]  regIdRn, heldIdRn;
    logic [63:0] regValRn;
    logic [1:0]  exHold;
    logic [7:0]  opUCmdOut;

    int   tests = 0;
    int   fails = 0;
    int   faultEdges = 0;
    logic prevFault = 1'b0;

    exb_lane_alu_pipe #(.DATA_W(64), .ID_W(6), .PIPE_L(2)) dut (
        .clock(clock), .reset(reset), .opUCmd(opUCmd), .opUIxt(opUIxt),
        .opBraFlush(opBraFlush), .exStall(exStall), .regIdRm(regIdRm),
        .regValRs(regValRs), .regValRt(regValRt), .regValImm(regValImm),
        .regInSrT(regInSrT), .regIdRn(regIdRn), .regValRn(regValRn),
        .heldIdRn(heldIdRn), .exHold(exHold), .opUCmdOut(opUCmdOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (exHold[0] && !prevFault) faultEdges++;
        prevFault = exHold[0];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [1:0] cc, input logic [5:0] op, input logic [7:0] ixt,
                           input logic [5:0] rm, input logic [63:0] rs, input logic [7:0] rt,
                           input logic [32:0] imm, input logic t);
        opUCmd    = {cc, op};
        opUIxt    = ixt;
        regIdRm   = rm;
        regValRs  = rs;
        regValRt  = rt;
        regValImm = imm;
        regInSrT  = t;
    endtask

    task automatic idle();
        present(2'b00, UCMD_NOP, 8'h00, 6'd0, 64'd0, 8'd0, 33'd0, 1'b0);
        opBraFlush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        exStall = 1'b0;
        idle();
        tick();
        tick();
        tests++; if (regIdRn !== ZZR) begin fails++; $display("FAIL reset.regIdRn got %h want %h", regIdRn, ZZR); end
        tests++; if (heldIdRn !== ZZR) begin fails++; $display("FAIL reset.heldIdRn got %h want %h", heldIdRn, ZZR); end
        tests++; if (regValRn !== 64'd0) begin fails++; $display("FAIL reset.regValRn got %h want 0", regValRn); end
        tests++; if (exHold !== 2'b00) begin fails++; $display("FAIL reset.exHold got %b want 00", exHold); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mov_ir();
        logic [7:0]  ixtT [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
        logic [32:0] immT [4] = '{33'h1_8000_0000, 33'h0_0000_0099, 33'h0_0000_ABCD, 33'h0_DEAD_BEEF};
        logic [63:0] expT [4] = '{64'hFFFF_FFFF_8000_0000, 64'h2233_4455_6677_8899,
                                  64'h3344_5566_7788_ABCD, 64'h5566_7788_DEAD_BEEF};
        for (int i = 0; i < 4; i++) begin
            present(2'b00, UCMD_MOV_IR, ixtT[i], 6'd5, 64'h1122_3344_5566_7788, 8'd0, immT[i], 1'b0);
            tick();
            idle();
            tests++; if (heldIdRn !== 6'd5 || exHold[1] !== 1'b1) begin
                fails++; $display("FAIL mov_ir[%0d].held got id=%h hold=%b want id=05 hold=1", i, heldIdRn, exHold[1]);
            end
            tests++; if (regIdRn !== ZZR) begin fails++; $display("FAIL mov_ir[%0d].early got %h want %h", i, regIdRn, ZZR); end
            tick();
            tests++; if (regIdRn !== 6'd5 || regValRn !== expT[i]) begin
                fails++; $display("FAIL mov_ir[%0d].result got id=%h val=%h want id=05 val=%h", i, regIdRn, regValRn, expT[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [7:0]  ixtT [9] = '{8'h01, 8'h01, 8'h00, 8'h02, 8'h03, 8'h03, 8'h02, 8'h00, 8'h01};
        logic [63:0] rsT  [9] = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_00F0,
                                  64'h8000_0000_0000_0010, 64'h8000_0000_0000_0010, 64'h8000_0000_0000_0010,
                                  64'h0000_0000_0000_0001, 64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000};
        logic [7:0]  rtT  [9] = '{8'hFC, 8'd40, 8'd4, 8'hFC, 8'hFC, 8'h80, 8'd63, 8'hF8, 8'd1};
        logic [63:0] expT [9] = '{64'hFFFF_FFFF_F800_0000, 64'h0, 64'h0000_0000_0000_0F00,
                                  64'h0800_0000_0000_0001, 64'hF800_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF,
                                  64'h8000_0000_0000_0000, 64'h0000_0000_0080_0000, 64'hFFFF_FFFF_8000_0000};
        for (int i = 0; i < 9; i++) begin
            present(2'b00, UCMD_SHAD3, ixtT[i], 6'd7, rsT[i], rtT[i], 33'd0, 1'b0);
            tick();
            idle();
            tick();
            tests++; if (regIdRn !== 6'd7 || regValRn !== expT[i]) begin
                fails++; $display("FAIL shift[%0d] got id=%h val=%h want id=07 val=%h", i, regIdRn, regValRn, expT[i]);
            end
        end
    endtask

    task automatic test_predication();
        logic [1:0] ccT  [6] = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10};
        logic       tT   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] ixtT [6] = '{IXS_MOVT, IXS_MOVT, IXS_MOVT, IXS_MOVNT, IXS_MOVT, IXS_MOVNT};
        logic [5:0] rmT  [6] = '{6'd3, 6'd3, 6'd9, 6'd10, 6'd4, 6'd11};
        logic [5:0] idT  [6] = '{ZZR, 6'd3, 6'd9, 6'd10, ZZR, 6'd11};
        logic [63:0] valT [6] = '{64'd0, 64'd0, 64'd1, 64'd1, 64'd0, 64'd0};
        logic [7:0] opT  [6] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
        for (int i = 0; i < 6; i++) begin
            present(ccT[i], UCMD_OP_IXS, ixtT[i], rmT[i], 64'hFFFF, 8'd0, 33'd0, tT[i]);
            #1;
            tests++; if (opUCmdOut !== opT[i]) begin
                fails++; $display("FAIL pred[%0d].opUCmdOut got %h want %h", i, opUCmdOut, opT[i]);
            end
            tick();
            idle();
            tick();
            tests++; if (regIdRn !== idT[i] || (idT[i] != ZZR && regValRn !== valT[i])) begin
                fails++; $display("FAIL pred[%0d].result got id=%h val=%h want id=%h val=%h", i, regIdRn, regValRn, idT[i], valT[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] opkT  [10] = '{6'd1, 6'd2, 6'd3, 6'd3, 6'd3, 6'd3, 6'd4, 6'd5, 6'd0, 6'd0};
        logic       stlT  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       flT   [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [5:0] heldT [10] = '{6'd1, 6'd2, 6'd2, 6'd2, 6'd2, 6'd3, ZZR, 6'd5, ZZR, ZZR};
        logic [5:0] outT  [10] = '{ZZR, 6'd1, 6'd1, 6'd1, 6'd1, 6'd2, 6'd3, ZZR, 6'd5, ZZR};
        logic [63:0] expVal;
        for (int c = 0; c < 10; c++) begin
            if (opkT[c] == 6'd0) idle();
            else present(2'b00, UCMD_MOV_IR, 8'h00, opkT[c], 64'd0, 8'd0, 33'(opkT[c]) * 33'h1111, 1'b0);
            exStall    = stlT[c];
            opBraFlush = flT[c];
            tick();
            expVal = 64'(outT[c]) * 64'h1111;
            tests++; if (heldIdRn !== heldT[c]) begin
                fails++; $display("FAIL b2b[%0d].heldIdRn got %h want %h", c, heldIdRn, heldT[c]);
            end
            tests++; if (regIdRn !== outT[c] || (outT[c] != ZZR && regValRn !== expVal)) begin
                fails++; $display("FAIL b2b[%0d].out got id=%h val=%h want id=%h val=%h", c, regIdRn, regValRn, outT[c], expVal);
            end
        end
        exStall    = 1'b0;
        opBraFlush = 1'b0;
    endtask

    task automatic test_rotate();
`ifdef JX2_EXB_SHAD_ROT_EN
        logic [7:0]  ixtT [3] = '{8'h06, 8'h04, 8'h05};
        logic [63:0] rsT  [3] = '{64'h1, 64'h0000_0000_8000_0001, 64'h1};
        logic [7:0]  rtT  [3] = '{8'hFF, 8'd1, 8'hFF};
        logic [63:0] expT [3] = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0003, 64'hFFFF_FFFF_8000_0000};
        for (int i = 0; i < 3; i++) begin
            present(2'b00, UCMD_SHAD3, ixtT[i], 6'd14, rsT[i], rtT[i], 33'd0, 1'b0);
            tick();
            idle();
            tick();
            tests++; if (regIdRn !== 6'd14 || regValRn !== expT[i]) begin
                fails++; $display("FAIL rotate[%0d] got id=%h val=%h want id=0e val=%h", i, regIdRn, regValRn, expT[i]);
            end
        end
`else
        present(2'b00, UCMD_SHAD3, 8'h06, 6'd14, 64'h1, 8'hFF, 33'd0, 1'b0);
        tick();
        idle();
        tests++; if (exHold[0] !== 1'b1) begin fails++; $display("FAIL rotate_off.fault got %b want 1", exHold[0]); end
        tick();
        tests++; if (regIdRn !== ZZR) begin fails++; $display("FAIL rotate_off.regIdRn got %h want %h", regIdRn, ZZR); end
`endif
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fault();
        int base;
        base = faultEdges;
        present(2'b01, UCMD_INVOP, 8'h00, 6'd2, 64'd0, 8'd0, 33'd0, 1'b0);
        tick();
        tests++; if (exHold[0] !== 1'b0) begin fails++; $display("FAIL fault.killed got %b want 0", exHold[0]); end
        present(2'b00, UCMD_INVOP, 8'h00, 6'd2, 64'd0, 8'd0, 33'd0, 1'b0);
        exStall = 1'b1;
        tick();
        tests++; if (exHold[0] !== 1'b0) begin fails++; $display("FAIL fault.stalled got %b want 0", exHold[0]); end
        exStall = 1'b0;
        tick();
        tests++; if (exHold[0] !== 1'b1) begin fails++; $display("FAIL fault.set got %b want 1", exHold[0]); end
        idle();
        tick();
        present(2'b00, UCMD_INVOP, 8'h00, 6'd2, 64'd0, 8'd0, 33'd0, 1'b0);
        tick();
        idle();
        repeat (3) tick();
        tests++; if (exHold[0] !== 1'b1) begin fails++; $display("FAIL fault.sticky got %b want 1", exHold[0]); end
        tests++; if (faultEdges - base !== 1) begin fails++; $display("FAIL fault.edges got %0d want 1", faultEdges - base); end
        tests++; if (regIdRn !== ZZR) begin fails++; $display("FAIL fault.nowb got %h want %h", regIdRn, ZZR); end
    endtask

    task automatic test_reset_mid();
        present(2'b00, UCMD_MOV_IR, 8'h00, 6'd12, 64'd0, 8'd0, 33'd5, 1'b0);
        tick();
        present(2'b00, UCMD_MOV_IR, 8'h00, 6'd13, 64'd0, 8'd0, 33'd6, 1'b0);
        tick();
        idle();
        tests++; if (regIdRn !== 6'd12 || heldIdRn !== 6'd13) begin
            fails++; $display("FAIL rstmid.pre got out=%h held=%h want out=0c held=0d", regIdRn, heldIdRn);
        end
        reset = 1'b1;
        #1;
        tests++; if (regIdRn !== ZZR || heldIdRn !== ZZR) begin
            fails++; $display("FAIL rstmid.ids got out=%h held=%h want %h", regIdRn, heldIdRn, ZZR);
        end
        tests++; if (exHold !== 2'b00 || regValRn !== 64'd0) begin
            fails++; $display("FAIL rstmid.hold got exHold=%b val=%h want 00/0", exHold, regValRn);
        end
        #1;
        reset = 1'b0;
        tick();
        tick();
        tests++; if (regIdRn !== ZZR) begin fails++; $display("FAIL rstmid.after got %h want %h", regIdRn, ZZR); end
    endtask

    initial begin
        opBraFlush = 1'b0;
        exStall    = 1'b0;
        test_reset();
        test_mov_ir();
        test_shift();
        test_predication();
        test_back_to_back();
        test_rotate();
        test_fault();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
